dmem_arbiter: RTL and testbench

//  Shares the single-port 32-bit data RAM between the processor load/store path (CPU) and an
//  I/O / boot-loader master (IO). Latches one request at a time, drives the RAM, returns read

---
 rtl/dmem_arb_pkg.sv | 20 ++
 rtl/rr_arbiter2.sv | 37 +++
 rtl/dmem_arbiter.sv | 152 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM state encoding,
// requester identifiers and the default RAM geometry.
package dmem_arb_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RDWAIT = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_IO  = 1'b1
    } owner_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker. A lone request always wins; on a tie the
// requester that was not granted last wins. The last-grant memory only moves
// when i_en is high, so the top can restrict updates to real grants.
module rr_arbiter2
    import dmem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_req,     // bit 0 = CPU, bit 1 = IO
    input  logic       i_en,
    output logic       o_valid,
    output owner_t     o_owner
);

    owner_t r_last_gnt;

    // Combinational pick from the current requests and the last grant.
    always_comb begin
        o_valid = |i_req;
        o_owner = OWN_CPU;
        if (i_req == 2'b11) begin
            o_owner = (r_last_gnt == OWN_CPU) ? OWN_IO : OWN_CPU;
        end else if (i_req[1]) begin
            o_owner = OWN_IO;
        end
    end

    // Remember who was granted; IO after reset so the CPU wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_gnt <= OWN_IO;
        end else if (i_en && o_valid) begin
            r_last_gnt <= o_owner;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data RAM between the CPU load/store path and an
// IO / boot-loader master. One access is in flight at a time: the winning
// request is latched in IDLE, driven to the RAM for one cycle, read data is
// captured a cycle later, and a one-cycle done pulse closes the access.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W,
    parameter int ADDR_WIDTH = ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    // CPU requester
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_done,
    output logic                  cpu_stall,
    // IO requester
    input  logic                  io_req,
    input  logic                  io_we,
    input  logic [ADDR_WIDTH-1:0] io_addr,
    input  logic [DATA_WIDTH-1:0] io_wdata,
    output logic [DATA_WIDTH-1:0] io_rdata,
    output logic                  io_done,
    // RAM side
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    state_t                r_state;
    state_t                w_state_next;
    owner_t                r_owner;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_cpu_rdata;
    logic [DATA_WIDTH-1:0] r_io_rdata;

    logic                  w_grant_en;
    logic                  w_gnt_valid;
    owner_t                w_gnt_owner;
    logic                  w_sel_we;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;

    assign w_grant_en = (r_state == ST_IDLE);

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .i_req   ({io_req, cpu_req}),
        .i_en    (w_grant_en),
        .o_valid (w_gnt_valid),
        .o_owner (w_gnt_owner)
    );

    // Route the winning requester's command toward the latch.
    always_comb begin
        w_sel_we    = cpu_we;
        w_sel_addr  = cpu_addr;
        w_sel_wdata = cpu_wdata;
        if (w_gnt_owner == OWN_IO) begin
            w_sel_we    = io_we;
            w_sel_addr  = io_addr;
            w_sel_wdata = io_wdata;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and RAM/done strobe decode. Strobes are masked while
    // reset is high so an abandoned access never writes the RAM or completes.
    always_comb begin
        w_state_next = r_state;
        mem_we       = 1'b0;
        mem_re       = 1'b0;
        cpu_done     = 1'b0;
        io_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_valid) begin
                    w_state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mem_we       = r_we & ~reset;
                mem_re       = ~r_we & ~reset;
                w_state_next = r_we ? ST_DONE : ST_RDWAIT;
            end
            ST_RDWAIT: begin
                w_state_next = ST_DONE;
            end
            ST_DONE: begin
                cpu_done     = (r_owner == OWN_CPU) & ~reset;
                io_done      = (r_owner == OWN_IO) & ~reset;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Request latch: later changes on the requester's bus are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner <= OWN_CPU;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_grant_en && w_gnt_valid) begin
            r_owner <= w_gnt_owner;
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
        end
    end

    // Per-requester read data, captured when the RAM output is valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cpu_rdata <= '0;
            r_io_rdata  <= '0;
        end else if (r_state == ST_RDWAIT) begin
            if (r_owner == OWN_CPU) begin
                r_cpu_rdata <= mem_rdata;
            end else begin
                r_io_rdata <= mem_rdata;
            end
        end
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign cpu_rdata = r_cpu_rdata;
    assign io_rdata  = r_io_rdata;
    assign cpu_stall = cpu_req & ~cpu_done;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed latency/arbitration/reset scenarios plus a
// randomized two-master phase. Drivers push expected completions into
// per-requester queues; a negedge monitor pops and compares on each done.
module tb_dmem_arbiter;

    typedef struct {
        bit          we;
        logic [7:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [7:0]  cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_done, cpu_stall;
    logic        io_req = 1'b0, io_we = 1'b0;
    logic [7:0]  io_addr = '0;
    logic [31:0] io_wdata = '0;
    logic [31:0] io_rdata;
    logic        io_done;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we, mem_re;
    logic [31:0] mem_rdata = '0;

    logic [31:0] ram     [256];
    logic [31:0] ref_mem [256];

    exp_t cpu_q[$];
    exp_t io_q[$];
    int   done_log[$];

    int          checks = 0;
    int          failures = 0;
    logic [31:0] m_cpu_rdata = '0;
    logic [31:0] m_io_rdata = '0;
    int          last_owner = 1;
    int          cpu_wait = 0;
    int          io_wait = 0;

    dmem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_done  (cpu_done),
        .cpu_stall (cpu_stall),
        .io_req    (io_req),
        .io_we     (io_we),
        .io_addr   (io_addr),
        .io_wdata  (io_wdata),
        .io_rdata  (io_rdata),
        .io_done   (io_done),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // RAM with registered read, as seen by the arbiter.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    // Monitor: compares completions against the queues and tracks rdata hold.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            m_cpu_rdata = '0;
            m_io_rdata  = '0;
            last_owner  = 1;
            cpu_wait    = 0;
            io_wait     = 0;
        end else begin
            if (cpu_done) begin
                done_log.push_back(0);
                last_owner = 0;
                if (cpu_q.size() == 0) begin
                    chk("cpu_unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = cpu_q.pop_front();
                    if (e.we) chk("cpu_wr_ram", ram[e.addr], e.data);
                    else begin
                        m_cpu_rdata = e.data;
                        chk("cpu_rd_data", cpu_rdata, e.data);
                    end
                    $display("txn cpu %s addr=%02h data=%08h", e.we ? "wr" : "rd", e.addr, e.data);
                end
            end
            if (io_done) begin
                done_log.push_back(1);
                last_owner = 1;
                if (io_q.size() == 0) begin
                    chk("io_unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = io_q.pop_front();
                    if (e.we) chk("io_wr_ram", ram[e.addr], e.data);
                    else begin
                        m_io_rdata = e.data;
                        chk("io_rd_data", io_rdata, e.data);
                    end
                    $display("txn io  %s addr=%02h data=%08h", e.we ? "wr" : "rd", e.addr, e.data);
                end
            end
            chk("cpu_rdata_hold", cpu_rdata, m_cpu_rdata);
            chk("io_rdata_hold", io_rdata, m_io_rdata);
            chk("cpu_stall", {31'd0, cpu_stall}, {31'd0, cpu_req & ~cpu_done});
            // A waiting requester may see at most one completion of the other side.
            if (io_done && cpu_req && !cpu_done) begin
                cpu_wait++;
                chk("cpu_fair", {31'd0, cpu_wait <= 1}, 32'd1);
            end
            if (cpu_done && io_req && !io_done) begin
                io_wait++;
                chk("io_fair", {31'd0, io_wait <= 1}, 32'd1);
            end
            if (cpu_done || !cpu_req) cpu_wait = 0;
            if (io_done || !io_req) io_wait = 0;
        end
    end

    // One complete access by requester `who` (0 = CPU, 1 = IO). Called just
    // after a rising edge; returns just after the edge that sampled done.
    task automatic xfer(input int who, input bit we, input logic [7:0] a, input logic [31:0] d);
        exp_t e;
        int   n;
        bit   got;
        e.we = we;
        e.addr = a;
        if (we) begin
            ref_mem[a] = d;
            e.data = d;
        end else begin
            e.data = ref_mem[a];
        end
        if (who == 0) begin
            cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
            cpu_q.push_back(e);
        end else begin
            io_we = we; io_addr = a; io_wdata = d; io_req = 1'b1;
            io_q.push_back(e);
        end
        n = 0;
        got = 1'b0;
        while (!got && n < 64) begin
            @(negedge clk);
            got = (who == 0) ? cpu_done : io_done;
            n++;
        end
        if (!got) chk(who == 0 ? "cpu_timeout" : "io_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (who == 0) begin
            cpu_req = 1'b0; cpu_addr = $urandom; cpu_wdata = $urandom;
        end else begin
            io_req = 1'b0; io_addr = $urandom; io_wdata = $urandom;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1; cpu_req = 1'b0; io_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic rand_run(input int who, input int n);
        bit         we;
        logic [7:0] a;
        int         gap;
        for (int k = 0; k < n; k++) begin
            we  = 1'($urandom_range(0, 1));
            a   = (who == 0) ? 8'(8'h60 + $urandom_range(0, 15)) : 8'(8'hA0 + $urandom_range(0, 15));
            xfer(who, we, a, $urandom);
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        exp_t e;
        int   exp_first;
        for (int i = 0; i < 256; i++) begin
            ram[i] = '0;
            ref_mem[i] = '0;
        end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_re", {31'd0, mem_re}, 32'd0);
        chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_io_done", {31'd0, io_done}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // CPU write 0x10 <= DEADBEEF, cycle-accurate.
        @(posedge clk);
        #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h10; cpu_wdata = 32'hDEADBEEF;
        e.we = 1'b1; e.addr = 8'h10; e.data = 32'hDEADBEEF;
        cpu_q.push_back(e);
        ref_mem[8'h10] = 32'hDEADBEEF;
        @(negedge clk);
        chk("t1_c0_stall", {31'd0, cpu_stall}, 32'd1);
        chk("t1_c0_we", {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        chk("t1_c1_we", {31'd0, mem_we}, 32'd1);
        chk("t1_c1_addr", {24'd0, mem_addr}, 32'h10);
        chk("t1_c1_wdata", mem_wdata, 32'hDEADBEEF);
        chk("t1_c1_stall", {31'd0, cpu_stall}, 32'd1);
        @(posedge clk);
        #1;
        cpu_addr = 8'h55; cpu_wdata = 32'h12345678;
        @(negedge clk);
        chk("t1_c2_done", {31'd0, cpu_done}, 32'd1);
        chk("t1_c2_stall", {31'd0, cpu_stall}, 32'd0);
        chk("t1_c2_we", {31'd0, mem_we}, 32'd0);
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        @(negedge clk);
        chk("t1_after_done", {31'd0, cpu_done}, 32'd0);

        // CPU read 0x10, cycle-accurate.
        @(posedge clk);
        #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
        e.we = 1'b0; e.addr = 8'h10; e.data = 32'hDEADBEEF;
        cpu_q.push_back(e);
        @(negedge clk);
        chk("t2_c0_re", {31'd0, mem_re}, 32'd0);
        @(negedge clk);
        chk("t2_c1_re", {31'd0, mem_re}, 32'd1);
        chk("t2_c1_we", {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        chk("t2_c2_re", {31'd0, mem_re}, 32'd0);
        chk("t2_c2_done", {31'd0, cpu_done}, 32'd0);
        @(negedge clk);
        chk("t2_c3_done", {31'd0, cpu_done}, 32'd1);
        chk("t2_c3_rdata", cpu_rdata, 32'hDEADBEEF);
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        repeat (5) @(negedge clk);
        chk("t2_rdata_held", cpu_rdata, 32'hDEADBEEF);

        // Ties after reset: CPU first; after a CPU-only grant, IO first.
        do_reset();
        done_log.delete();
        exp_first = 1 - last_owner;
        fork
            xfer(0, 1'b1, 8'h30, 32'hC0C0_0001);
            xfer(1, 1'b1, 8'h31, 32'h1010_0001);
        join
        chk("t3_log_len", done_log.size(), 32'd2);
        chk("t3_first_after_rst", done_log[0], 32'd0);
        chk("t3_first_rule", done_log[0], exp_first);
        xfer(0, 1'b0, 8'h30, 32'h0);
        done_log.delete();
        exp_first = 1 - last_owner;
        fork
            xfer(0, 1'b0, 8'h31, 32'h0);
            xfer(1, 1'b0, 8'h30, 32'h0);
        join
        chk("t3_second_first", done_log[0], 32'd1);
        chk("t3_second_rule", done_log[0], exp_first);

        // IO back-to-back writes 0..3, CPU requests during the first.
        done_log.delete();
        fork
            for (int i = 0; i < 4; i++) xfer(1, 1'b1, 8'(i), 32'hA5A5_0000 + 32'(i * 17));
            begin
                @(posedge clk);
                #1;
                xfer(0, 1'b1, 8'h40, 32'h0000_4040);
            end
        join
        chk("t4_log_len", done_log.size(), 32'd5);
        chk("t4_first_io", done_log[0], 32'd1);
        chk("t4_cpu_second", done_log[1], 32'd0);
        for (int i = 0; i < 4; i++) xfer(1, 1'b0, 8'(i), 32'h0);

        // Reset during the ACCESS cycle of a CPU write.
        xfer(0, 1'b0, 8'h10, 32'h0);
        @(posedge clk);
        #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h20; cpu_wdata = 32'h1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("t5_we_gated", {31'd0, mem_we}, 32'd0);
        chk("t5_no_done", {31'd0, cpu_done}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cpu_req = 1'b0;
        @(negedge clk);
        chk("t5_ram_untouched", ram[8'h20], ref_mem[8'h20]);
        chk("t5_cpu_rdata_clr", cpu_rdata, 32'd0);
        chk("t5_io_rdata_clr", io_rdata, 32'd0);
        chk("t5_done_after", {31'd0, cpu_done}, 32'd0);
        xfer(0, 1'b0, 8'h20, 32'h0);

        // Idle for 100 cycles: no strobes or completions.
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("t6_idle", {28'd0, mem_we, mem_re, cpu_done, io_done}, 32'd0);
        end

        // Randomized concurrent traffic on disjoint address windows.
        @(posedge clk);
        #1;
        fork
            rand_run(0, 40);
            rand_run(1, 40);
        join
        repeat (4) @(negedge clk);
        chk("end_cpu_q_empty", cpu_q.size(), 32'd0);
        chk("end_io_q_empty", io_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
